// File: rtl/uart_esram_loader.sv
// rtl/uart_esram_loader.sv - boot image loader: framed UART bytes -> exec SRAM over TL-UL
// Optional trailing checksum byte is enabled by defining UART_ESRAM_LOADER_CSUM_EN.
package tlul_pkg;
   typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
   typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
   typedef struct packed {
      logic [4:0] rsvd;
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;
   parameter tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'd0, instr_type: 4'h9, cmd_intg: 7'd0, data_intg: 7'd0};
   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [13:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module uart_esram_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned MAX_WORDS = 16384,
   parameter logic [7:0]  MAGIC     = 8'hA5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic              byte_ready_o,
   output tlul_pkg::tl_h2d_t tl_o,
   input  tlul_pkg::tl_d2h_t tl_i,
   output logic              boot_hold_o,
   output logic              done_o,
   output logic              err_o,
   output logic [14:0]       words_o
);
   typedef enum logic [3:0] {IDLE, LEN0, LEN1, DATA, WRITE, RESP, CSUM, DONE, ERR} state_e;

   state_e      state_q;
   logic [7:0]  len_lo_q;
   logic [15:0] len_q;
   logic [31:0] word_q;
   logic [1:0]  bcnt_q;
   logic [14:0] idx_q;
   logic        a_valid_q;
   logic        boot_hold_q;
   logic        done_q;
   logic        err_q;
`ifdef UART_ESRAM_LOADER_CSUM_EN
   logic [7:0]  csum_q;
`endif

   logic        byte_fire;
   logic [15:0] len_d;
   logic [15:0] idx_d;
   logic        unused_tl;

   assign byte_ready_o = (state_q == IDLE) || (state_q == LEN0) || (state_q == LEN1) ||
                         (state_q == DATA) || (state_q == CSUM);
   assign byte_fire    = byte_valid_i & byte_ready_o;
   assign len_d        = {byte_i, len_lo_q};
   assign idx_d        = {1'b0, idx_q} + 16'd1;
   assign boot_hold_o  = boot_hold_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign words_o      = idx_q;
   assign unused_tl    = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                           tl_i.d_sink, tl_i.d_data, tl_i.d_user};

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_valid_q;
      tl_o.a_opcode  = tlul_pkg::PutFullData;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_source  = 8'd0;
      tl_o.a_address = BASE_ADDR + {15'd0, idx_q, 2'b00};
      tl_o.a_data    = word_q;
      tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         len_lo_q    <= 8'd0;
         len_q       <= 16'd0;
         word_q      <= 32'd0;
         bcnt_q      <= 2'd0;
         idx_q       <= 15'd0;
         a_valid_q   <= 1'b0;
         boot_hold_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef UART_ESRAM_LOADER_CSUM_EN
         csum_q      <= 8'd0;
`endif
      end else begin
         case (state_q)
            IDLE: if (byte_fire && byte_i == MAGIC) state_q <= LEN0;
            LEN0: if (byte_fire) begin
               len_lo_q <= byte_i;
               state_q  <= LEN1;
            end
            LEN1: if (byte_fire) begin
               len_q <= len_d;
               if (len_d > 16'(MAX_WORDS)) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else if (len_d == 16'd0) begin
`ifdef UART_ESRAM_LOADER_CSUM_EN
                  state_q <= CSUM;
`else
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  boot_hold_q <= 1'b0;
`endif
               end else begin
                  state_q <= DATA;
               end
            end
            // Little-endian assembly: after four shifts the first byte sits in [7:0].
            DATA: if (byte_fire) begin
               word_q <= {byte_i, word_q[31:8]};
               bcnt_q <= bcnt_q + 2'd1;
`ifdef UART_ESRAM_LOADER_CSUM_EN
               csum_q <= csum_q ^ byte_i;
`endif
               if (bcnt_q == 2'd3) begin
                  state_q   <= WRITE;
                  a_valid_q <= 1'b1;
               end
            end
            WRITE: if (tl_i.a_ready) begin
               state_q   <= RESP;
               a_valid_q <= 1'b0;
            end
            RESP: if (tl_i.d_valid) begin
               if (tl_i.d_error) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else begin
                  idx_q <= idx_d[14:0];
                  if (idx_d == len_q) begin
`ifdef UART_ESRAM_LOADER_CSUM_EN
                     state_q <= CSUM;
`else
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     boot_hold_q <= 1'b0;
`endif
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            CSUM: if (byte_fire) begin
`ifdef UART_ESRAM_LOADER_CSUM_EN
               if (byte_i == csum_q) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  boot_hold_q <= 1'b0;
               end else begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end
`else
               state_q <= ERR;
               err_q   <= 1'b1;
`endif
            end
            DONE:    state_q <= DONE;
            ERR:     state_q <= ERR;
            default: state_q <= ERR;
         endcase
      end
   end
endmodule
